// File: rtl/ddr3_rw_arbiter.sv
// Round-robin sequencer for the DDR3 user interface: camera write bursts drain the
// write FIFO into a linear frame buffer, display read bursts refill the read FIFO.
module ddr3_rw_arbiter #(
    parameter int BURST_LEN   = 16,
    parameter int ADDR_W      = 29,
    parameter int ADDR_STEP   = 8,
    parameter int FRAME_WORDS = 115200
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              calib_done,
    input  logic              wr_trig,
    input  logic              rd_trig,
    input  logic              wr_sof,
    input  logic              vga_vsync,
    output logic              wfifo_rd_en,
    input  logic [127:0]      wfifo_rd_data,
    output logic              rfifo_wr_en,
    output logic [127:0]      rfifo_wr_data,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic              app_rdy,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic [127:0]      app_wdf_data,
    input  logic              app_wdf_rdy,
    input  logic [127:0]      app_rd_data,
    input  logic              app_rd_data_valid,
    output logic              busy
);

    localparam int                CNT_W     = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(ADDR_STEP);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_WORDS * ADDR_STEP - ADDR_STEP);
    localparam logic [2:0]        CMD_WR    = 3'b000;
    localparam logic [2:0]        CMD_RD    = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_READ     = 2'd2,
        ST_RD_DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;
    logic [CNT_W-1:0]    ccnt_q, ccnt_d;
    logic [CNT_W-1:0]    dcnt_q, dcnt_d;
    logic                last_rd_q, last_rd_d;
    logic                pend_wclr_q, pend_wclr_d;
    logic                pend_rclr_q, pend_rclr_d;
    logic                rfifo_wr_en_q;
    logic [127:0]        rfifo_wr_data_q;

    logic                rd_req_s;
    logic                wr_hs_s;
    logic                app_en_s;
    logic [2:0]          app_cmd_s;
    logic [ADDR_W-1:0]   app_addr_s;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
        if (addr == ADDR_LAST) begin
            next_addr = '0;
        end else begin
            next_addr = addr + ADDR_INC;
        end
    endfunction

    assign rd_req_s = rd_trig && !vga_vsync;

    // Next-state, pointer and counter logic plus the command-side outputs
    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        wcnt_d      = wcnt_q;
        ccnt_d      = ccnt_q;
        last_rd_d   = last_rd_q;
        pend_wclr_d = pend_wclr_q;
        pend_rclr_d = pend_rclr_q;
        wr_hs_s     = 1'b0;
        app_en_s    = 1'b0;
        app_cmd_s   = CMD_RD;
        app_addr_s  = rd_addr_q;

        // Late returns after a reset land in IDLE and must not count toward a burst
        if ((state_q == ST_READ || state_q == ST_RD_DRAIN) && app_rd_data_valid) begin
            dcnt_d = dcnt_q + CNT_ONE;
        end else begin
            dcnt_d = dcnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                wr_addr_d = wr_sof ? '0 : wr_addr_q;
                rd_addr_d = vga_vsync ? '0 : rd_addr_q;
                if (calib_done) begin
                    if (wr_trig && (!rd_req_s || last_rd_q)) begin
                        state_d   = ST_WRITE;
                        last_rd_d = 1'b0;
                    end else if (rd_req_s) begin
                        state_d   = ST_READ;
                        last_rd_d = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                wr_hs_s     = app_rdy && app_wdf_rdy;
                app_en_s    = wr_hs_s;
                app_cmd_s   = CMD_WR;
                app_addr_s  = wr_addr_q;
                rd_addr_d   = vga_vsync ? '0 : rd_addr_q;
                pend_wclr_d = pend_wclr_q | wr_sof;
                if (wr_hs_s) begin
                    wr_addr_d = next_addr(wr_addr_q);
                    wcnt_d    = wcnt_q + CNT_ONE;
                    if (wcnt_q == CNT_LAST) begin
                        // A frame start seen during the burst takes effect only now
                        state_d     = ST_IDLE;
                        wcnt_d      = '0;
                        pend_wclr_d = 1'b0;
                        wr_addr_d   = (pend_wclr_q || wr_sof) ? '0 : next_addr(wr_addr_q);
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                app_en_s    = 1'b1;
                app_cmd_s   = CMD_RD;
                app_addr_s  = rd_addr_q;
                wr_addr_d   = wr_sof ? '0 : wr_addr_q;
                pend_rclr_d = pend_rclr_q | vga_vsync;
                if (app_rdy) begin
                    rd_addr_d = next_addr(rd_addr_q);
                    ccnt_d    = ccnt_q + CNT_ONE;
                    if (ccnt_q == CNT_LAST) begin
                        state_d = ST_RD_DRAIN;
                        ccnt_d  = '0;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_RD_DRAIN: begin
                wr_addr_d   = wr_sof ? '0 : wr_addr_q;
                pend_rclr_d = pend_rclr_q | vga_vsync;
                if (dcnt_q == CNT_FULL) begin
                    state_d     = ST_IDLE;
                    dcnt_d      = '0;
                    pend_rclr_d = 1'b0;
                    rd_addr_d   = (pend_rclr_q || vga_vsync) ? '0 : rd_addr_q;
                end else begin
                    state_d = ST_RD_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointers, counters and the registered read-return path
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q         <= ST_IDLE;
            wr_addr_q       <= '0;
            rd_addr_q       <= '0;
            wcnt_q          <= '0;
            ccnt_q          <= '0;
            dcnt_q          <= '0;
            last_rd_q       <= 1'b1;
            pend_wclr_q     <= 1'b0;
            pend_rclr_q     <= 1'b0;
            rfifo_wr_en_q   <= 1'b0;
            rfifo_wr_data_q <= '0;
        end else begin
            state_q         <= state_d;
            wr_addr_q       <= wr_addr_d;
            rd_addr_q       <= rd_addr_d;
            wcnt_q          <= wcnt_d;
            ccnt_q          <= ccnt_d;
            dcnt_q          <= dcnt_d;
            last_rd_q       <= last_rd_d;
            pend_wclr_q     <= pend_wclr_d;
            pend_rclr_q     <= pend_rclr_d;
            rfifo_wr_en_q   <= app_rd_data_valid;
            rfifo_wr_data_q <= app_rd_data;
        end
    end

    assign app_en        = app_en_s;
    assign app_cmd       = app_cmd_s;
    assign app_addr      = app_addr_s;
    assign app_wdf_wren  = wr_hs_s;
    assign app_wdf_end   = wr_hs_s;
    assign app_wdf_data  = wfifo_rd_data;
    assign wfifo_rd_en   = wr_hs_s;
    assign rfifo_wr_en   = rfifo_wr_en_q;
    assign rfifo_wr_data = rfifo_wr_data_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// Scoreboard bench for ddr3_rw_arbiter: a burst-level model predicts the command stream,
// a monitor compares accepted commands and read-FIFO pushes against it.
module tb_ddr3_rw_arbiter;

    localparam int BL   = 16;
    localparam int AW   = 29;
    localparam int STEP = 8;
    localparam int FW   = 64;
    localparam int SPAN = FW * STEP;
    localparam int TMO  = 3000;

    logic          sclk = 1'b0;
    logic          s_rst, calib_done, wr_trig, rd_trig, wr_sof, vga_vsync;
    logic          wfifo_rd_en;
    logic [127:0]  wfifo_rd_data;
    logic          rfifo_wr_en;
    logic [127:0]  rfifo_wr_data;
    logic          app_en;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic          app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [127:0]  app_wdf_data, app_rd_data;
    logic          app_rd_data_valid;
    logic          busy;

    int checks = 0;
    int errors = 0;

    bit [2:0]     exp_cmd_q[$];
    int           exp_addr_q[$];
    logic [127:0] resp_q[$];
    logic [127:0] rfifo_exp_q[$];

    int m_wr_ptr  = 0;
    int m_rd_ptr  = 0;
    bit m_last_rd = 1'b1;

    int rdy_mode   = 0;
    bit resp_hold  = 1'b0;
    int wr_beats   = 0;
    int rd_cmds    = 0;
    int cyc        = 0;
    bit last_was_rd = 1'b0;
    bit prev_busy   = 1'b0;
    bit prev_rst    = 1'b1;

    ddr3_rw_arbiter #(.BURST_LEN(BL), .ADDR_W(AW), .ADDR_STEP(STEP), .FRAME_WORDS(FW)) dut (
        .sclk(sclk), .s_rst(s_rst), .calib_done(calib_done),
        .wr_trig(wr_trig), .rd_trig(rd_trig), .wr_sof(wr_sof), .vga_vsync(vga_vsync),
        .wfifo_rd_en(wfifo_rd_en), .wfifo_rd_data(wfifo_rd_data),
        .rfifo_wr_en(rfifo_wr_en), .rfifo_wr_data(rfifo_wr_data),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .busy(busy)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // One burst of the reference: 16 contiguous beats on a frame-sized ring
    task automatic model_burst(input bit is_rd);
        for (int i = 0; i < BL; i++) begin
            if (is_rd) begin
                exp_cmd_q.push_back(3'b001);
                exp_addr_q.push_back(m_rd_ptr);
                m_rd_ptr = (m_rd_ptr + STEP) % SPAN;
            end else begin
                exp_cmd_q.push_back(3'b000);
                exp_addr_q.push_back(m_wr_ptr);
                m_wr_ptr = (m_wr_ptr + STEP) % SPAN;
            end
        end
        m_last_rd = is_rd;
    endtask

    task automatic flush_all();
        exp_cmd_q.delete();
        exp_addr_q.delete();
        resp_q.delete();
        rfifo_exp_q.delete();
    endtask

    task automatic wait_below(input int lim, input string name);
        int t = 0;
        while (exp_cmd_q.size() >= lim && t < TMO) begin
            @(posedge sclk); #1;
            t++;
        end
        if (t >= TMO) fail_timeout(name);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((exp_cmd_q.size() != 0 || busy || resp_q.size() != 0 || rfifo_exp_q.size() != 0)
               && t < TMO) begin
            @(posedge sclk); #1;
            t++;
        end
        if (t >= TMO) begin
            fail_timeout(name);
            flush_all();
        end
    endtask

    task automatic idle_hold(input int n, input string name);
        repeat (n) begin
            @(negedge sclk);
            check(name, busy, 0);
        end
        @(posedge sclk); #1;
    endtask

    task automatic check_reset_outs(input string name);
        check({name, "_busy"},  busy, 0);
        check({name, "_en"},    app_en, 0);
        check({name, "_cmd"},   app_cmd, 3'b001);
        check({name, "_addr"},  app_addr, 0);
        check({name, "_wstb"},  {wfifo_rd_en, app_wdf_wren, app_wdf_end}, 0);
        check({name, "_rfifo"}, rfifo_wr_en, 0);
    endtask

    // Held triggers give a deterministic grant order: alternate when both, else the one asked
    task automatic run_bursts(input bit w, input bit r, input int n);
        for (int k = 0; k < n; k++) begin
            if (w && r) model_burst(!m_last_rd);
            else        model_burst(r);
        end
        wr_trig = w;
        rd_trig = r;
        wait_below(BL, "burst_start");
        wr_trig = 1'b0;
        rd_trig = 1'b0;
        wait_idle("burst_done");
    endtask

    // Controller-side ready/data driver
    initial begin
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        wfifo_rd_data = '0;
        forever begin
            @(posedge sclk); #1;
            cyc++;
            case (rdy_mode)
                1: begin
                    app_rdy     = ($urandom_range(0, 3) != 0);
                    app_wdf_rdy = ($urandom_range(0, 3) != 0);
                end
                2: begin
                    app_rdy     = 1'b1;
                    app_wdf_rdy = (cyc % 3 != 0);
                end
                default: begin
                    app_rdy     = 1'b1;
                    app_wdf_rdy = 1'b1;
                end
            endcase
            wfifo_rd_data = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // Read-return responder with random gaps
    initial begin
        app_rd_data_valid = 1'b0;
        app_rd_data = '0;
        forever begin
            @(posedge sclk); #1;
            if (!resp_hold && resp_q.size() != 0 && $urandom_range(0, 3) != 0) begin
                app_rd_data = resp_q.pop_front();
                app_rd_data_valid = 1'b1;
                rfifo_exp_q.push_back(app_rd_data);
            end else begin
                app_rd_data_valid = 1'b0;
                app_rd_data = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // Monitor: compares accepted commands, write strobes and read-FIFO pushes
    always @(negedge sclk) begin : mon
        bit [2:0] c;
        int       a;
        if (app_cmd == 3'b000) begin
            check("wr_strobes", {app_en, wfifo_rd_en, app_wdf_wren, app_wdf_end},
                  {4{app_rdy && app_wdf_rdy}});
        end else if (wfifo_rd_en || app_wdf_wren || app_wdf_end) begin
            check("rd_strobes", {wfifo_rd_en, app_wdf_wren, app_wdf_end}, 0);
        end
        if (app_en && app_rdy) begin
            if (exp_cmd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd: got cmd %0d addr %0d, required no command",
                         app_cmd, app_addr);
            end else begin
                c = exp_cmd_q.pop_front();
                a = exp_addr_q.pop_front();
                check("cmd", app_cmd, c);
                check("addr", app_addr, a);
                if (c == 3'b000) begin
                    check("wdf_data", app_wdf_data, wfifo_rd_data);
                end
            end
            if (app_cmd == 3'b001) begin
                resp_q.push_back({$urandom, $urandom, $urandom, $urandom});
                rd_cmds++;
                last_was_rd = 1'b1;
            end else begin
                wr_beats++;
                last_was_rd = 1'b0;
            end
        end
        if (rfifo_wr_en) begin
            if (rfifo_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rfifo: got push %0h, required no push", rfifo_wr_data);
            end else begin
                check("rfifo_data", rfifo_wr_data, rfifo_exp_q.pop_front());
            end
        end
        if (prev_busy && !busy && last_was_rd && !prev_rst) begin
            check("drain_done", resp_q.size(), 0);
        end
        prev_busy = busy;
        prev_rst  = s_rst;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        s_rst = 1'b1; calib_done = 1'b0; wr_trig = 1'b0; rd_trig = 1'b0;
        wr_sof = 1'b0; vga_vsync = 1'b0;
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        check_reset_outs("reset");
        @(posedge sclk); #1;
        s_rst = 1'b0;

        // No grants before calibration
        wr_trig = 1'b1; rd_trig = 1'b1;
        idle_hold(10, "calib_low");
        wr_trig = 1'b0; rd_trig = 1'b0; calib_done = 1'b1;

        rdy_mode = 1; run_bursts(1'b1, 1'b1, 4);
        rdy_mode = 0; run_bursts(1'b1, 1'b0, 2);
        rdy_mode = 2; run_bursts(1'b1, 1'b0, 3);
        rdy_mode = 1; run_bursts(1'b0, 1'b1, 3);
        rdy_mode = 0;

        // Frame start mid-burst: burst stays contiguous, next burst restarts at 0
        base = wr_beats;
        model_burst(1'b0);
        wr_trig = 1'b1;
        wait_below(BL, "sof_start");
        wr_trig = 1'b0;
        t = 0;
        while (wr_beats < base + 5 && t < TMO) begin
            @(posedge sclk); #1;
            t++;
        end
        if (t >= TMO) fail_timeout("sof_beat5");
        wr_sof = 1'b1;
        @(posedge sclk); #1;
        wr_sof = 1'b0;
        wait_idle("sof_mid");
        m_wr_ptr = 0;
        run_bursts(1'b1, 1'b0, 1);

        // Frame start while idle
        wr_sof = 1'b1;
        @(posedge sclk); #1;
        wr_sof = 1'b0;
        m_wr_ptr = 0;
        run_bursts(1'b1, 1'b0, 1);

        // Vsync blocks read grants and rewinds the read pointer
        vga_vsync = 1'b1; rd_trig = 1'b1;
        idle_hold(8, "vsync_block");
        rd_trig = 1'b0;
        @(posedge sclk); #1;
        vga_vsync = 1'b0;
        m_rd_ptr = 0;
        run_bursts(1'b0, 1'b1, 1);
        run_bursts(1'b0, 1'b1, 1);

        // Vsync during a read burst is deferred to the burst end
        base = rd_cmds;
        model_burst(1'b1);
        rd_trig = 1'b1;
        wait_below(BL, "vs_start");
        rd_trig = 1'b0;
        t = 0;
        while (rd_cmds < base + 4 && t < TMO) begin
            @(posedge sclk); #1;
            t++;
        end
        if (t >= TMO) fail_timeout("vs_beat4");
        vga_vsync = 1'b1;
        repeat (2) begin @(posedge sclk); #1; end
        vga_vsync = 1'b0;
        wait_idle("vs_mid");
        m_rd_ptr = 0;
        run_bursts(1'b0, 1'b1, 1);

        // Calibration lost mid-burst: burst completes, no further grants
        model_burst(1'b0);
        wr_trig = 1'b1;
        wait_below(BL, "calib_start");
        calib_done = 1'b0;
        wait_idle("calib_fall");
        idle_hold(10, "calib_fall_idle");
        wr_trig = 1'b0;
        calib_done = 1'b1;

        // Reset during a read burst after 7 commands
        resp_hold = 1'b1;
        base = rd_cmds;
        model_burst(1'b1);
        rd_trig = 1'b1;
        t = 0;
        while (rd_cmds < base + 7 && t < TMO) begin
            @(posedge sclk); #1;
            t++;
        end
        if (t >= TMO) fail_timeout("rst_beat7");
        s_rst = 1'b1;
        rd_trig = 1'b0;
        @(posedge sclk); #1;
        s_rst = 1'b0;
        @(negedge sclk);
        check_reset_outs("rst_mid");
        exp_cmd_q.delete();
        exp_addr_q.delete();
        m_rd_ptr = 0; m_wr_ptr = 0; m_last_rd = 1'b1;
        @(posedge sclk); #1;
        resp_hold = 1'b0;
        idle_hold(20, "late_return");
        wait_idle("late_drain");

        // Fresh read burst from 0 must wait in drain for all 16 returns
        resp_hold = 1'b1;
        model_burst(1'b1);
        rd_trig = 1'b1;
        wait_below(BL, "post_rst_start");
        rd_trig = 1'b0;
        wait_below(1, "post_rst_cmds");
        repeat (5) begin
            @(negedge sclk);
            check("drain_wait", busy, 1);
        end
        @(posedge sclk); #1;
        resp_hold = 1'b0;
        wait_idle("post_rst_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr3_rw_arbiter.md
Name: ddr3_rw_arbiter

Overview:
- Sequences the shared DDR3 controller user interface between the camera write path and the HDMI read path.
- Watches the write-FIFO level trigger (wr_trig) and the read-FIFO low-water trigger (rd_trig), arbitrates round-robin, and issues fixed-length bursts of 128-bit commands.
- Write bursts drain the write FIFO into DDR3; read bursts fill the read FIFO from DDR3.
- Maintains one linear frame buffer with separate write and read address pointers. Sits between fifo_ctrl and the DDR3 controller, in the controller's user clock domain.

Parameters:
- BURST_LEN, 16, 128-bit beats per burst; matches the wr_trig threshold.
- ADDR_W, 29, DDR3 user address width.
- ADDR_STEP, 8, address increment per 128-bit beat (x16 device, BL8).
- FRAME_WORDS, 115200, 128-bit words per frame (1280x720x16 bit / 128); multiple of BURST_LEN.

Ports:
- sclk  in  1  user-interface clock; all logic on rising edge.
- s_rst  in  1  synchronous reset, active-high.
- calib_done  in  1  DDR3 calibration complete; no arbitration while low.
- wr_trig  in  1  write FIFO holds >= BURST_LEN words.
- rd_trig  in  1  read FIFO below low-water mark.
- wr_sof  in  1  single-cycle pulse, camera frame start (already synchronised to sclk).
- vga_vsync  in  1  display vsync level (already synchronised to sclk).
- wfifo_rd_en  out  1  pop the write FIFO (FWFT).
- wfifo_rd_data  in  128  write FIFO head word.
- rfifo_wr_en  out  1  push the read FIFO.
- rfifo_wr_data  out  128  read FIFO data.
- app_en  out  1  command valid.
- app_cmd  out  3  3'b000 write, 3'b001 read.
- app_addr  out  ADDR_W  command address.
- app_rdy  in  1  command accepted when app_en && app_rdy.
- app_wdf_wren  out  1  write data valid.
- app_wdf_end  out  1  equal to app_wdf_wren (one beat per command).
- app_wdf_data  out  128  equal to wfifo_rd_data.
- app_wdf_rdy  in  1  write data accepted.
- app_rd_data  in  128  read return data.
- app_rd_data_valid  in  1  read return valid.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE; wr_addr = 0, rd_addr = 0; beat counters 0; last_grant = READ (write wins the first tie); pend_wclr = 0, pend_rclr = 0. All outputs 0 except app_cmd = 3'b001 and app_addr = 0.
- States: IDLE, WRITE, READ, RD_DRAIN.
- IDLE:
  - Arbitrate only when calib_done = 1.
  - Read request is rd_trig && !vga_vsync.
  - Only write requested -> WRITE; only read requested -> READ.
  - Both requested -> grant the type opposite to last_grant.
  - last_grant updates on entry to WRITE or READ. Transition takes 1 cycle.
- WRITE:
  - app_en = app_wdf_wren = app_rdy && app_wdf_rdy; app_cmd = 000; app_addr = wr_addr.
  - wfifo_rd_en = the same handshake. Command and data are issued together; no beat is split.
  - Each handshake: wr_addr += ADDR_STEP, wrapping to 0 after FRAME_WORDS*ADDR_STEP - ADDR_STEP; wcnt += 1.
  - wcnt = BURST_LEN-1 with a handshake -> IDLE, wcnt = 0.
- READ:
  - app_en = 1; app_cmd = 001; app_addr = rd_addr.
  - Each app_rdy: rd_addr += ADDR_STEP with the same wrap; ccnt += 1.
  - Last command accepted -> RD_DRAIN.
- Return data (independent of state):
  - rfifo_wr_en = app_rd_data_valid, registered 1 cycle; rfifo_wr_data is registered with it.
  - Each valid beat increments dcnt.
  - RD_DRAIN -> IDLE when dcnt reaches BURST_LEN; dcnt is then cleared.
- Frame pointer control:
  - wr_sof outside WRITE: wr_addr <= 0 next cycle.
  - wr_sof inside WRITE: set pend_wclr; apply it on the WRITE->IDLE transition so the burst is never split.
  - vga_vsync = 1 clears rd_addr the same way, deferred via pend_rclr during READ/RD_DRAIN.
  - Data returned during vsync is still pushed; the read FIFO is held in reset by vsync, so that data is dropped.
- Simultaneous events: wr_sof on the same cycle as the final write handshake -> wr_addr = 0 (the clear overrides the increment).
- calib_done falling mid-burst: the current burst completes; no new grants are issued.
- s_rst mid-burst: immediate return to reset state. Outstanding read returns arriving after reset are ignored; dcnt stays 0 in IDLE.

Test Plan:
- Hold wr_trig = 1, app_rdy = app_wdf_rdy = 1 -> exactly 16 consecutive write commands at addr 0,8,...,120, 16 wfifo_rd_en pulses, then IDLE; next burst starts at 128.
- wr_trig = rd_trig = 1 continuously -> grants alternate W,R,W,R starting with W; each read burst waits for 16 rd_data_valid before the next grant.
- Toggle app_wdf_rdy low every third cycle in WRITE -> no app_en, app_wdf_wren or wfifo_rd_en on those cycles; still 16 beats, with addresses contiguous.
- Preload wr_addr to FRAME_WORDS*8-128, run one write burst -> last command at FRAME_WORDS*8-8, then wr_addr = 0.
- Pulse wr_sof at write beat 5 -> burst continues at addr+48..., and wr_addr = 0 after burst end. vga_vsync high with rd_trig = 1 -> no read grant and rd_addr = 0.
- Assert s_rst during READ after 7 commands -> next cycle IDLE, all outputs at reset values, rd_addr = 0; late rd_data_valid causes no state change.
